operand_fetch_stage: RTL and testbench

//  ID/EX pipeline stage directly downstream of the register file. Drives read addresses AA/BA,

---
 rtl/operand_fetch_stage_pkg.sv | 28 ++
 rtl/operand_forward_mux.sv | 52 +++++
 rtl/operand_fetch_stage.sv | 151 +++++++++++++++
 tb/tb_operand_fetch_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants and types for the ID/EX operand fetch stage.
// Forward-select encoding and control bundle layout live here.
package operand_fetch_stage_pkg;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 5;
    localparam int CTRL_BITS   = 16;
    localparam int HAZ_CNT_W   = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Field offsets inside the opaque control bundle (decoded in EX only)
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 6;
    localparam int CTRL_BR_LSB     = 6;
    localparam int CTRL_BR_W       = 4;
    localparam int CTRL_MISC_LSB   = 10;
    localparam int CTRL_MISC_W     = 6;

    typedef enum logic [2:0] {
        FWD_ZERO = 3'd0,
        FWD_EX   = 3'd1,
        FWD_MEM  = 3'd2,
        FWD_WB   = 3'd3,
        FWD_RF   = 3'd4
    } fwd_sel_e;

endpackage

// File: rtl/operand_forward_mux.sv
// Per-operand bypass selector: R0, then EX, MEM, WB writers, else register file.
module operand_forward_mux
    import operand_fetch_stage_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] rf_data,
    input  logic          ex_fwd_en,
    input  logic [AW-1:0] ex_da,
    input  logic [DW-1:0] ex_result,
    input  logic          mem_rw,
    input  logic [AW-1:0] mem_da,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_rw,
    input  logic [AW-1:0] wb_da,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] data
);

    fwd_sel_e sel_s;

    // Priority select; a matching address of R0 never reaches the writer checks
    always_comb begin
        sel_s = FWD_RF;
        if (addr == AW'(REG_ZERO)) begin
            sel_s = FWD_ZERO;
        end else if (ex_fwd_en && (ex_da == addr)) begin
            sel_s = FWD_EX;
        end else if (mem_rw && (mem_da == addr)) begin
            sel_s = FWD_MEM;
        end else if (wb_rw && (wb_da == addr)) begin
            sel_s = FWD_WB;
        end else begin
            sel_s = FWD_RF;
        end
    end

    // Data steering for the chosen source
    always_comb begin
        case (sel_s)
            FWD_ZERO: data = {DW{1'b0}};
            FWD_EX:   data = ex_result;
            FWD_MEM:  data = mem_result;
            FWD_WB:   data = wb_data;
            FWD_RF:   data = rf_data;
            default:  data = rf_data;
        endcase
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID/EX stage: register-file addressing, operand forwarding, load-use stall,
// ID/EX pipeline register with valid/ready handshake and saturating stall counter.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int DW     = DATA_W,
    parameter int AW     = ADDR_W,
    parameter int CTRL_W = CTRL_BITS,
    parameter int CNT_W  = HAZ_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [AW-1:0]     id_aa,
    input  logic [AW-1:0]     id_ba,
    input  logic [AW-1:0]     id_da,
    input  logic              id_rw,
    input  logic              id_mr,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [AW-1:0]     rf_aa,
    output logic [AW-1:0]     rf_ba,
    input  logic [DW-1:0]     rf_a,
    input  logic [DW-1:0]     rf_b,
    input  logic [DW-1:0]     ex_result,
    input  logic [AW-1:0]     mem_da,
    input  logic              mem_rw,
    input  logic [DW-1:0]     mem_result,
    input  logic [AW-1:0]     wb_da,
    input  logic              wb_rw,
    input  logic [DW-1:0]     wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DW-1:0]     ex_a,
    output logic [DW-1:0]     ex_b,
    output logic [AW-1:0]     ex_da,
    output logic              ex_rw,
    output logic              ex_mr,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  hazard_cnt
);

    logic              ex_valid_r;
    logic [DW-1:0]     ex_a_r;
    logic [DW-1:0]     ex_b_r;
    logic [AW-1:0]     ex_da_r;
    logic              ex_rw_r;
    logic              ex_mr_r;
    logic [CTRL_W-1:0] ex_ctrl_r;
    logic [CNT_W-1:0]  hazard_cnt_r;

    logic              ex_fwd_en_s;
    logic              hazard_s;
    logic              handshake_s;
    logic [DW-1:0]     fwd_a_s;
    logic [DW-1:0]     fwd_b_s;

    assign rf_aa = id_aa;
    assign rf_ba = id_ba;

    // A load in EX has no result yet, so it is never a bypass source
    assign ex_fwd_en_s = ex_valid_r & ex_rw_r & ~ex_mr_r;

    assign hazard_s = id_valid & ex_valid_r & ex_mr_r & ex_rw_r
                    & (ex_da_r != AW'(REG_ZERO))
                    & ((ex_da_r == id_aa) | (ex_da_r == id_ba));

    assign id_ready    = ex_ready & ~hazard_s;
    assign handshake_s = id_valid & id_ready;

    operand_forward_mux #(.DW(DW), .AW(AW)) u_fwd_a (
        .addr       (id_aa),
        .rf_data    (rf_a),
        .ex_fwd_en  (ex_fwd_en_s),
        .ex_da      (ex_da_r),
        .ex_result  (ex_result),
        .mem_rw     (mem_rw),
        .mem_da     (mem_da),
        .mem_result (mem_result),
        .wb_rw      (wb_rw),
        .wb_da      (wb_da),
        .wb_data    (wb_data),
        .data       (fwd_a_s)
    );

    operand_forward_mux #(.DW(DW), .AW(AW)) u_fwd_b (
        .addr       (id_ba),
        .rf_data    (rf_b),
        .ex_fwd_en  (ex_fwd_en_s),
        .ex_da      (ex_da_r),
        .ex_result  (ex_result),
        .mem_rw     (mem_rw),
        .mem_da     (mem_da),
        .mem_result (mem_result),
        .wb_rw      (wb_rw),
        .wb_da      (wb_da),
        .wb_data    (wb_data),
        .data       (fwd_b_s)
    );

    // ID/EX pipeline register: flush beats load/bubble; stall holds everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_r <= 1'b0;
            ex_a_r     <= {DW{1'b0}};
            ex_b_r     <= {DW{1'b0}};
            ex_da_r    <= {AW{1'b0}};
            ex_rw_r    <= 1'b0;
            ex_mr_r    <= 1'b0;
            ex_ctrl_r  <= {CTRL_W{1'b0}};
        end else if (flush) begin
            ex_valid_r <= 1'b0;
            ex_rw_r    <= 1'b0;
            ex_mr_r    <= 1'b0;
        end else if (ex_ready) begin
            if (handshake_s) begin
                ex_valid_r <= 1'b1;
                ex_a_r     <= fwd_a_s;
                ex_b_r     <= fwd_b_s;
                ex_da_r    <= id_da;
                ex_rw_r    <= id_rw;
                ex_mr_r    <= id_mr;
                ex_ctrl_r  <= id_ctrl;
            end else begin
                ex_valid_r <= 1'b0;
                ex_rw_r    <= 1'b0;
                ex_mr_r    <= 1'b0;
            end
        end
    end

    // Load-use stall counter, sticks at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hazard_cnt_r <= {CNT_W{1'b0}};
        end else if (hazard_s && ex_ready && (hazard_cnt_r != {CNT_W{1'b1}})) begin
            hazard_cnt_r <= hazard_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ex_valid   = ex_valid_r;
    assign ex_a       = ex_a_r;
    assign ex_b       = ex_b_r;
    assign ex_da      = ex_da_r;
    assign ex_rw      = ex_rw_r;
    assign ex_mr      = ex_mr_r;
    assign ex_ctrl    = ex_ctrl_r;
    assign hazard_cnt = hazard_cnt_r;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed vector table, hand sequences and
// randomized traffic against a behavioural pipeline model.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_rw, id_mr, flush, ex_ready;
    logic [4:0]  id_aa, id_ba, id_da, mem_da, wb_da;
    logic [15:0] id_ctrl;
    logic [31:0] rf_a, rf_b, ex_result, mem_result, wb_data;
    logic        mem_rw, wb_rw;

    logic        id_ready, ex_valid, ex_rw, ex_mr;
    logic [4:0]  rf_aa, rf_ba, ex_da;
    logic [31:0] ex_a, ex_b;
    logic [15:0] ex_ctrl, hazard_cnt;

    logic        s_id_ready, s_ex_valid, s_ex_rw, s_ex_mr;
    logic [4:0]  s_rf_aa, s_rf_ba, s_ex_da;
    logic [31:0] s_ex_a, s_ex_b;
    logic [15:0] s_ex_ctrl;
    logic [2:0]  s_hazard_cnt;

    always #5 clk = ~clk;

    operand_fetch_stage u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_aa(id_aa), .id_ba(id_ba), .id_da(id_da), .id_rw(id_rw), .id_mr(id_mr),
        .id_ctrl(id_ctrl), .rf_aa(rf_aa), .rf_ba(rf_ba), .rf_a(rf_a), .rf_b(rf_b),
        .ex_result(ex_result), .mem_da(mem_da), .mem_rw(mem_rw), .mem_result(mem_result),
        .wb_da(wb_da), .wb_rw(wb_rw), .wb_data(wb_data), .flush(flush),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_da(ex_da), .ex_rw(ex_rw), .ex_mr(ex_mr), .ex_ctrl(ex_ctrl),
        .hazard_cnt(hazard_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a short run
    operand_fetch_stage #(.CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(s_id_ready),
        .id_aa(id_aa), .id_ba(id_ba), .id_da(id_da), .id_rw(id_rw), .id_mr(id_mr),
        .id_ctrl(id_ctrl), .rf_aa(s_rf_aa), .rf_ba(s_rf_ba), .rf_a(rf_a), .rf_b(rf_b),
        .ex_result(ex_result), .mem_da(mem_da), .mem_rw(mem_rw), .mem_result(mem_result),
        .wb_da(wb_da), .wb_rw(wb_rw), .wb_data(wb_data), .flush(flush),
        .ex_ready(ex_ready), .ex_valid(s_ex_valid), .ex_a(s_ex_a), .ex_b(s_ex_b),
        .ex_da(s_ex_da), .ex_rw(s_ex_rw), .ex_mr(s_ex_mr), .ex_ctrl(s_ex_ctrl),
        .hazard_cnt(s_hazard_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of what sits in the ID/EX register
    bit          m_known = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_bubble = 1'b0;
    bit          m_rst = 1'b0;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_da;
    bit          m_rw, m_mr;
    logic [15:0] m_ctrl;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] x, input logic [31:0] rf);
        if (x == 5'd0) return 32'd0;
        if (m_valid && m_rw && !m_mr && m_da == x) return ex_result;
        if (mem_rw && mem_da == x) return mem_result;
        if (wb_rw && wb_da == x) return wb_data;
        return rf;
    endfunction

    function automatic bit m_hazard();
        return id_valid && m_valid && m_mr && m_rw && (m_da != 5'd0)
               && (m_da == id_aa || m_da == id_ba);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock: check combinational outputs, advance model, check registers
    task automatic run_cycle();
        bit          haz, rdy;
        logic [31:0] na, nb;
        #2;
        haz = m_hazard();
        rdy = ex_ready && !haz;
        if (m_known) begin
            chk("id_ready", id_ready, rdy);
            chk("sat_id_ready", s_id_ready, rdy);
        end
        chk("rf_aa", rf_aa, id_aa);
        chk("rf_ba", rf_ba, id_ba);
        na = m_fwd(id_aa, rf_a);
        nb = m_fwd(id_ba, rf_b);
        m_rst = 1'b0;
        if (!rst_n) begin
            m_valid = 0; m_bubble = 0; m_rst = 1; m_cnt = 0;
            m_a = 0; m_b = 0; m_da = 0; m_rw = 0; m_mr = 0; m_ctrl = 0;
            m_known = 1'b1;
        end else begin
            if (haz && ex_ready) m_cnt++;
            if (flush) begin
                m_valid = 0; m_bubble = 0;
            end else if (ex_ready) begin
                if (id_valid && rdy) begin
                    m_valid = 1; m_bubble = 0;
                    m_a = na; m_b = nb; m_da = id_da; m_rw = id_rw; m_mr = id_mr; m_ctrl = id_ctrl;
                end else begin
                    m_valid = 0; m_bubble = 1; m_rw = 0; m_mr = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (m_known) begin
            chk("ex_valid", ex_valid, m_valid);
            chk("sat_ex_valid", s_ex_valid, m_valid);
            chk("hazard_cnt", hazard_cnt, sat(m_cnt, 65535));
            chk("sat_hazard_cnt", s_hazard_cnt, sat(m_cnt, 7));
            if (m_valid || m_rst) begin
                chk("ex_a", ex_a, m_a);
                chk("ex_b", ex_b, m_b);
                chk("ex_da", ex_da, m_da);
                chk("ex_rw", ex_rw, m_rw);
                chk("ex_mr", ex_mr, m_mr);
                chk("ex_ctrl", ex_ctrl, m_ctrl);
            end
            if (m_bubble) begin
                chk("bubble_rw", ex_rw, 1'b0);
                chk("bubble_mr", ex_mr, 1'b0);
            end
        end
    endtask

    typedef struct {
        bit fl, rdy, v; logic [4:0] aa, ba, da; bit rw, mr;
        logic [31:0] exr; bit mrw; logic [4:0] mda; logic [31:0] mres;
        bit wrw; logic [4:0] wda; logic [31:0] wdat;
        bit e_ready, e_valid, chk_a; logic [31:0] e_a; int e_cnt;
    } vec_t;

    function automatic vec_t mk(bit fl, bit rdy, bit v, logic [4:0] aa, logic [4:0] ba,
                                logic [4:0] da, bit rw, bit mr, logic [31:0] exr,
                                bit mrw, logic [4:0] mda, logic [31:0] mres,
                                bit wrw, logic [4:0] wda, logic [31:0] wdat,
                                bit e_ready, bit e_valid, bit chk_a, logic [31:0] e_a, int e_cnt);
        vec_t t;
        t.fl = fl; t.rdy = rdy; t.v = v; t.aa = aa; t.ba = ba; t.da = da; t.rw = rw; t.mr = mr;
        t.exr = exr; t.mrw = mrw; t.mda = mda; t.mres = mres; t.wrw = wrw; t.wda = wda;
        t.wdat = wdat; t.e_ready = e_ready; t.e_valid = e_valid; t.chk_a = chk_a;
        t.e_a = e_a; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic set_instr(input bit v, input logic [4:0] aa, input logic [4:0] ba,
                             input logic [4:0] da, input bit rw, input bit mr);
        id_valid = v; id_aa = aa; id_ba = ba; id_da = da; id_rw = rw; id_mr = mr;
    endtask

    vec_t tbl[12];

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        set_instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        id_ctrl = 16'hBEEF; rf_a = 32'hA0; rf_b = 32'hB0;
        ex_result = 32'd0; mem_rw = 1'b0; mem_da = 5'd0; mem_result = 32'd0;
        wb_rw = 1'b0; wb_da = 5'd0; wb_data = 32'd0;

        // Reset held two cycles with an instruction offered
        run_cycle();
        run_cycle();
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_ex_a", ex_a, 32'd0);
        chk("rst_hazard_cnt", hazard_cnt, 16'd0);
        rst_n = 1'b1;

        tbl[0]  = mk(0,1,1, 5'd1,5'd2,5'd3, 1,0, 32'h0,  0,5'd0,32'h0,   0,5'd0,32'h0,   1,1,1,32'hA0,0);
        tbl[1]  = mk(0,1,1, 5'd3,5'd1,5'd4, 1,0, 32'h55, 0,5'd0,32'h0,   0,5'd0,32'h0,   1,1,1,32'h55,0);
        tbl[2]  = mk(0,1,1, 5'd5,5'd0,5'd0, 1,0, 32'h99, 1,5'd5,32'h11,  1,5'd5,32'h22,  1,1,1,32'h11,0);
        tbl[3]  = mk(0,1,1, 5'd0,5'd0,5'd7, 1,1, 32'h77, 1,5'd0,32'h11,  1,5'd0,32'h22,  1,1,1,32'h0,0);
        tbl[4]  = mk(0,1,1, 5'd7,5'd2,5'd8, 1,0, 32'h0,  0,5'd0,32'h0,   0,5'd0,32'h0,   0,0,0,32'h0,1);
        tbl[5]  = mk(0,1,1, 5'd7,5'd2,5'd8, 1,0, 32'h0,  1,5'd7,32'h3C,  0,5'd0,32'h0,   1,1,1,32'h3C,1);
        tbl[6]  = mk(0,0,1, 5'd1,5'd2,5'd9, 1,0, 32'h0,  0,5'd0,32'h0,   0,5'd0,32'h0,   0,1,1,32'h3C,1);
        tbl[7]  = tbl[6];
        tbl[8]  = tbl[6];
        tbl[9]  = mk(0,1,1, 5'd1,5'd2,5'd9, 1,0, 32'h0,  0,5'd0,32'h0,   0,5'd0,32'h0,   1,1,1,32'hA0,1);
        tbl[10] = mk(1,1,1, 5'd2,5'd1,5'd10,1,0, 32'h0,  0,5'd0,32'h0,   0,5'd0,32'h0,   1,0,0,32'h0,1);
        tbl[11] = mk(0,1,0, 5'd1,5'd1,5'd0, 0,0, 32'h0,  0,5'd0,32'h0,   0,5'd0,32'h0,   1,0,0,32'h0,1);

        for (int i = 0; i < 12; i++) begin
            flush = tbl[i].fl; ex_ready = tbl[i].rdy;
            set_instr(tbl[i].v, tbl[i].aa, tbl[i].ba, tbl[i].da, tbl[i].rw, tbl[i].mr);
            id_ctrl = 16'(i);
            ex_result = tbl[i].exr;
            mem_rw = tbl[i].mrw; mem_da = tbl[i].mda; mem_result = tbl[i].mres;
            wb_rw = tbl[i].wrw; wb_da = tbl[i].wda; wb_data = tbl[i].wdat;
            #1;
            chk($sformatf("tbl%0d_id_ready", i), id_ready, tbl[i].e_ready);
            run_cycle();
            chk($sformatf("tbl%0d_ex_valid", i), ex_valid, tbl[i].e_valid);
            if (tbl[i].chk_a) chk($sformatf("tbl%0d_ex_a", i), ex_a, tbl[i].e_a);
            chk($sformatf("tbl%0d_hazard_cnt", i), hazard_cnt, 16'(tbl[i].e_cnt));
        end

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 99) < 8);
            ex_ready = ($urandom_range(0, 99) < 80);
            set_instr($urandom_range(0, 99) < 80, 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 40);
            id_ctrl = 16'($urandom);
            rf_a = $urandom; rf_b = $urandom; ex_result = $urandom;
            mem_rw = $urandom_range(0, 1); mem_da = 5'($urandom_range(0, 7)); mem_result = $urandom;
            wb_rw = $urandom_range(0, 1); wb_da = 5'($urandom_range(0, 7)); wb_data = $urandom;
            run_cycle();
        end

        // Back-to-back dependent loads: one stall every second cycle
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        mem_rw = 1'b0; wb_rw = 1'b0;
        run_cycle();
        rst_n = 1'b1;
        set_instr(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) run_cycle();
        chk("seq_hazard_cnt", hazard_cnt, 16'd10);
        chk("seq_sat_hazard_cnt", s_hazard_cnt, 3'd7);

        // Flush and handshake in the same cycle drops the instruction
        set_instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        run_cycle();
        flush = 1'b1;
        set_instr(1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0);
        run_cycle();
        chk("flush_ex_valid", ex_valid, 1'b0);
        flush = 1'b0; id_valid = 1'b0;
        run_cycle();
        chk("flush_dropped", ex_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
